bmu_modport: RTL and testbench

- Single-cycle, registered bit-manipulation unit (BMU) for the integer execute pipe.
- Computes AND, XOR, logical shift left or arithmetic shift right of two operands, selected by a one-hot opcode bundle `ap`.
- Optional Zbb-style inverted-operand variants (ANDN, XNOR).
- Also forwards CSR read data; result and illegal-operation flag are available one cycle after issue.

---
 rtl/bmu_modport.sv | 53 +++++
 tb/tb_bmu_modport.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/bmu_modport.sv
// bmu_modport: registered bit-manipulation unit (AND/XOR/SLL/SRA) with CSR read forwarding.
// Define BMU_ZBB_EN to honour the zbb bit (ANDN/XNOR); otherwise zbb makes any issue illegal.
module bmu_modport #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rstL,
   input  logic             scanMode,
   input  logic             validIn,
   input  logic [4:0]       ap,
   input  logic             csrRenIn,
   input  logic [WIDTH-1:0] csrRdataIn,
   input  logic [WIDTH-1:0] aIn,
   input  logic [WIDTH-1:0] bIn,
   output logic [WIDTH-1:0] resultFf,
   output logic             error
);
   localparam int SW = $clog2(WIDTH);
   logic             zbb, land, lxor, sll, sra;
   logic             one_op, zbb_ok, legal;
   logic [SW-1:0]    shamt;
   logic [WIDTH-1:0] b_eff, op_result, result_nxt;
   assign {zbb, land, lxor, sll, sra} = ap;
   assign shamt  = bIn[SW-1:0];
   assign one_op = {land, lxor, sll, sra} inside {4'b1000, 4'b0100, 4'b0010, 4'b0001};
`ifdef BMU_ZBB_EN
   assign zbb_ok = !zbb || land || lxor;
   assign b_eff  = zbb ? ~bIn : bIn;
`else
   assign zbb_ok = !zbb;
   assign b_eff  = bIn;
`endif
   assign legal = validIn && !csrRenIn && one_op && zbb_ok;
   always_comb begin
      op_result  = land ? (aIn & b_eff) :
                   lxor ? (aIn ^ b_eff) :
                   sll  ? (aIn << shamt) :
                          $unsigned($signed(aIn) >>> shamt);
      // issue beats CSR read; idle holds unless scan forces the register to load zero
      result_nxt = validIn  ? (legal ? op_result : '0) :
                   csrRenIn ? csrRdataIn :
                   scanMode ? '0 : resultFf;
   end
   always_ff @(posedge clk or negedge rstL) begin
      if (!rstL) begin
         resultFf <= '0;
         error    <= 1'b0;
      end else begin
         resultFf <= result_nxt;
         error    <= validIn && !legal;
      end
   end
endmodule

// File: tb/tb_bmu_modport.sv
// tb_bmu_modport: directed self-checking bench for bmu_modport.
module tb_bmu_modport;
   logic        clk = 1'b0;
   logic        rstL, scanMode, validIn, csrRenIn;
   logic [4:0]  ap;
   logic [31:0] csrRdataIn, aIn, bIn, resultFf;
   logic        error;
   int          total = 0;
   int          bad = 0;

   bmu_modport #(.WIDTH(32)) dut (
      .clk(clk), .rstL(rstL), .scanMode(scanMode), .validIn(validIn), .ap(ap),
      .csrRenIn(csrRenIn), .csrRdataIn(csrRdataIn), .aIn(aIn), .bIn(bIn),
      .resultFf(resultFf), .error(error)
   );

   always #5 clk = ~clk;

   task automatic drive(input logic v, input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic c, input logic [31:0] cd, input logic s);
      validIn = v; ap = op; aIn = a; bIn = b; csrRenIn = c; csrRdataIn = cd; scanMode = s;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      rstL = 1'b0;
      validIn = 1'b0; ap = '0; aIn = '0; bIn = '0; csrRenIn = 1'b0; csrRdataIn = '0; scanMode = 1'b0;
      #1;
      total++;
      if (resultFf !== 32'h0 || error !== 1'b0) begin
         bad++; $display("FAIL reset_init: got %h/%b want 00000000/0", resultFf, error);
      end
      @(posedge clk); #2 rstL = 1'b1;
      drive(1'b0, 5'b0, '0, '0, 1'b1, 32'hDEADBEEF, 1'b0);
      total++;
      if (resultFf !== 32'hDEADBEEF) begin
         bad++; $display("FAIL reset_preload: got %h want deadbeef", resultFf);
      end
      #2 rstL = 1'b0;
      #1;
      total++;
      if (resultFf !== 32'h0 || error !== 1'b0) begin
         bad++; $display("FAIL reset_async: got %h/%b want 00000000/0", resultFf, error);
      end
      @(posedge clk); #2 rstL = 1'b1;
      drive(1'b0, 5'b0, '0, '0, 1'b0, '0, 1'b0);
      total++;
      if (resultFf !== 32'h0 || error !== 1'b0) begin
         bad++; $display("FAIL reset_release: got %h/%b want 00000000/0", resultFf, error);
      end
   endtask

   task automatic test_logic;
      logic [4:0]  ops [4] = '{5'b01000, 5'b00100, 5'b11000, 5'b10100};
`ifdef BMU_ZBB_EN
      logic [31:0] exp [4] = '{32'hF000F000, 32'h0FF00FF0, 32'h00F000F0, 32'hF00FF00F};
      logic        eer [4] = '{1'b0, 1'b0, 1'b0, 1'b0};
`else
      logic [31:0] exp [4] = '{32'hF000F000, 32'h0FF00FF0, 32'h0, 32'h0};
      logic        eer [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
`endif
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, ops[i], 32'hF0F0F0F0, 32'hFF00FF00, 1'b0, '0, 1'b0);
         total++;
         if (resultFf !== exp[i] || error !== eer[i]) begin
            bad++; $display("FAIL logic_op%0d: got %h/%b want %h/%b", i, resultFf, error, exp[i], eer[i]);
         end
      end
   endtask

   task automatic test_shift;
      logic [31:0] av [3] = '{32'h00000001, 32'h80000000, 32'h40000000};
      logic [31:0] bv [3] = '{32'h00000024, 32'd31, 32'd1};
      logic [4:0]  ops [3] = '{5'b00010, 5'b00001, 5'b00001};
      logic [31:0] exp [3] = '{32'h00000010, 32'hFFFFFFFF, 32'h20000000};
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, ops[i], av[i], bv[i], 1'b0, '0, 1'b0);
         total++;
         if (resultFf !== exp[i] || error !== 1'b0) begin
            bad++; $display("FAIL shift%0d: got %h/%b want %h/0", i, resultFf, error, exp[i]);
         end
      end
   endtask

   task automatic test_csr;
      drive(1'b0, 5'b11111, 32'h1, 32'h1, 1'b1, 32'h12345678, 1'b0);
      total++;
      if (resultFf !== 32'h12345678 || error !== 1'b0) begin
         bad++; $display("FAIL csr_read: got %h/%b want 12345678/0", resultFf, error);
      end
      drive(1'b0, 5'b0, '0, '0, 1'b0, '0, 1'b0);
      total++;
      if (resultFf !== 32'h12345678 || error !== 1'b0) begin
         bad++; $display("FAIL csr_hold: got %h/%b want 12345678/0", resultFf, error);
      end
      drive(1'b0, 5'b0, '0, '0, 1'b0, '0, 1'b1);
      total++;
      if (resultFf !== 32'h0 || error !== 1'b0) begin
         bad++; $display("FAIL scan_clear: got %h/%b want 00000000/0", resultFf, error);
      end
   endtask

   task automatic test_illegal;
      logic [4:0] ops [4] = '{5'b01100, 5'b10010, 5'b00000, 5'b01000};
      logic       csr [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 5'b01000, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, '0, 1'b0);
         drive(1'b1, ops[i], 32'hFFFFFFFF, 32'h0000000F, csr[i], 32'hCAFEF00D, 1'b0);
         total++;
         if (resultFf !== 32'h0 || error !== 1'b1) begin
            bad++; $display("FAIL illegal%0d: got %h/%b want 00000000/1", i, resultFf, error);
         end
         drive(1'b0, 5'b0, '0, '0, 1'b0, '0, 1'b0);
         total++;
         if (resultFf !== 32'h0 || error !== 1'b0) begin
            bad++; $display("FAIL illegal%0d_pulse: got %h/%b want 00000000/0", i, resultFf, error);
         end
      end
   endtask

   task automatic test_back_to_back;
      drive(1'b1, 5'b00100, 32'hAAAA5555, 32'h0000FFFF, 1'b0, '0, 1'b0);
      total++;
      if (resultFf !== 32'hAAAAAAAA || error !== 1'b0) begin
         bad++; $display("FAIL b2b_xor: got %h/%b want aaaaaaaa/0", resultFf, error);
      end
      drive(1'b1, 5'b00001, 32'h7FFFFFF0, 32'hFFFFFFE4, 1'b0, '0, 1'b0);
      total++;
      if (resultFf !== 32'h07FFFFFF || error !== 1'b0) begin
         bad++; $display("FAIL b2b_sra: got %h/%b want 07ffffff/0", resultFf, error);
      end
   endtask

   initial begin
      test_reset;
      test_logic;
      test_shift;
      test_csr;
      test_illegal;
      test_back_to_back;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
